// File: rtl/md_issue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_issue_pkg
//  Description : Shared definitions for the multiply/divide issue controller:
//                md op codes (as defined by md.h), issue FSM state encoding,
//                the queued request record and small op-classification
//                helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package md_issue_pkg;

    // Op codes understood by the md unit (mirrors md.h).
    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;

    // Issue FSM state encodings (md_issue.h).
    typedef enum logic [1:0] {
        MD_ISSUE_IDLE  = 2'd0,
        MD_ISSUE_ISSUE = 2'd1,
        MD_ISSUE_WAIT  = 2'd2
    } md_issue_state_e;

    // One queued request: {op, a, b} = 68 bits.
    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } md_req_t;

    localparam int MD_REQ_W = $bits(md_req_t);

    function automatic logic md_op_legal(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) ||
               (op == MD_DIVU) || (op == MD_MTHI)  || (op == MD_MTLO);
    endfunction

    // Ops that keep md busy for several cycles after issue.
    function automatic logic md_op_long(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    function automatic logic md_op_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : md_fifo
//  Description : Synchronous FIFO holding queued md requests.
//                Ports: clk, rst_n (async active-low), push/push_data,
//                pop/pop_data (head entry, valid when !empty), full, empty,
//                count (occupancy, 0..DEPTH).
//  Revision    : 1.0 - initial release
// ============================================================================
module md_fifo
    import md_issue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = MD_REQ_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointers wrap naturally.
    always_comb begin
        w_do_push = push && !full;
        w_do_pop  = pop && !empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (w_do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (w_do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read when count says valid.
    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/md_issue.sv
`default_nettype none
// ============================================================================
//  Module      : md_issue
//  Description : Issue/interlock controller between EX and the md unit.
//                Queues MULT/MULTU/DIV/DIVU/MTHI/MTLO requests, issues them
//                in order one per md idle window, and stalls MFHI/MFLO
//                until all queued and in-flight work has retired.
//                Ports: req_* (EX request side, req_ready = not full),
//                rd_* (MFHI/MFLO read, rd_stall/rd_data), div0 (divide by
//                zero pulse), md_op/md_dh/md_dl (to md), md_busy/md_hi/
//                md_lo (from md).
//  Revision    : 1.0 - initial release
// ============================================================================
module md_issue
    import md_issue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        req_ready,
    input  logic        rd_valid,
    input  logic        rd_sel,
    output logic        rd_stall,
    output logic [31:0] rd_data,
    output logic        div0,
    output logic [3:0]  md_op,
    output logic [31:0] md_dh,
    output logic [31:0] md_dl,
    input  logic        md_busy,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo
);

    md_issue_state_e       state_q, state_d;
    logic [3:0]            md_op_q, md_op_d;
    logic [31:0]           md_dh_q, md_dh_d;
    logic [31:0]           md_dl_q, md_dl_d;
    logic                  div0_q,  div0_d;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [$clog2(DEPTH):0] w_count;
    md_req_t               w_push_req;
    logic [MD_REQ_W-1:0]   w_head_raw;
    md_req_t               w_head;

    // Illegal codes are silently dropped rather than queued.
    assign req_ready  = !w_full;
    assign w_push     = req_valid && req_ready && md_op_legal(req_op);
    assign w_push_req = '{op: req_op, a: req_a, b: req_b};
    assign w_head     = md_req_t'(w_head_raw);

    md_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (MD_REQ_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_push_req),
        .pop       (w_pop),
        .pop_data  (w_head_raw),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    always_comb begin
        state_d = state_q;
        md_op_d = MD_NONE;
        md_dh_d = md_dh_q;
        md_dl_d = md_dl_q;
        div0_d  = 1'b0;
        w_pop   = 1'b0;
        case (state_q)
            MD_ISSUE_IDLE: begin
                // After a reset md may still be finishing an old op.
                if (!w_empty && !md_busy) begin
                    w_pop   = 1'b1;
                    md_op_d = w_head.op;
                    md_dh_d = w_head.a;
                    md_dl_d = w_head.b;
                    div0_d  = md_op_div(w_head.op) && (w_head.b == 32'd0);
                    state_d = MD_ISSUE_ISSUE;
                end
            end
            MD_ISSUE_ISSUE: begin
                state_d = md_op_long(md_op_q) ? MD_ISSUE_WAIT : MD_ISSUE_IDLE;
            end
            MD_ISSUE_WAIT: begin
                if (!md_busy) state_d = MD_ISSUE_IDLE;
            end
            default: state_d = MD_ISSUE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_ISSUE_IDLE;
            md_op_q <= MD_NONE;
            md_dh_q <= 32'd0;
            md_dl_q <= 32'd0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            md_op_q <= md_op_d;
            md_dh_q <= md_dh_d;
            md_dl_q <= md_dl_d;
            div0_q  <= div0_d;
        end
    end

    assign md_op = md_op_q;
    assign md_dh = md_dh_q;
    assign md_dl = md_dl_q;
    assign div0  = div0_q;

    // A push in the same cycle also stalls the read: its op lands in the
    // FIFO at the edge and must retire before HI/LO are meaningful.
    assign rd_stall = rd_valid && ((w_count != '0) || w_push ||
                                   (state_q != MD_ISSUE_IDLE) || md_busy);
    assign rd_data  = rd_sel ? md_hi : md_lo;

endmodule
`default_nettype wire
